regfile_multiport: RTL and testbench

Parametrised multi-read-port integer register file with x0 hardwired to zero, a per-register busy scoreboard and a post-reset clearing sweep. It sits in the decode/issue stage of the RISC-V core. It supplies up to NUM_READ operands per cycle plus a hazard (busy) flag per operand. The writeback stage drives the single write port.

---
 rtl/regfile_multiport.sv | 131 +++++++++++++
 tb/tb_regfile_multiport.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-read-port integer register file for the decode/issue
// stage. x0 reads as zero and is never busy; a per-register busy scoreboard
// tracks in-flight producers; a clearing sweep zeroes storage after reset.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding in the
// write cycle). Default build (macro undefined) reads storage only.
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ready,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]       rd_busy
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [WIDTH-1:0]  mem_q [1:DEPTH-1];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              wr_hit;
  logic              rsv_hit;

  assign ready   = (state_q == RUN);
  assign wr_hit  = ready && wr_en && (wr_addr != '0);
  assign rsv_hit = ready && rsv_en && (rsv_addr != '0);

  // Sweep FSM next state: walk cnt from 1 to DEPTH-1, then enter RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Scoreboard next state: write clears, reserve sets (reserve wins on a tie).
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_hit) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Control registers: FSM state, sweep counter and busy bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= ONE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage write select: the sweep owns the port during INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_hit) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array (no reset; the sweep clears it). Writes in a reset cycle drop.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports: independent combinational lookups, x0 and not-ready read zero.
  always_comb begin
    logic [AW-1:0] raddr;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      raddr = rd_addr[i*AW +: AW];
      if (ready && (raddr != '0)) begin
        rd_data[i*WIDTH +: WIDTH] = mem_q[raddr];
        rd_busy[i]                = busy_q[raddr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (wr_addr == raddr)) begin
          rd_data[i*WIDTH +: WIDTH] = wr_data;
          rd_busy[i]                = rsv_en && (rsv_addr == raddr);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with DEPTH=32, NUM_READ=4.
module tb_regfile_multiport;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 4;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*WIDTH-1:0] rd_data;
  logic [NR-1:0]     rd_busy;

  int n_cmp = 0;
  int n_mis = 0;

  regfile_multiport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NR)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  function automatic logic [31:0] port_data(input int p);
    return rd_data[p*WIDTH +: WIDTH];
  endfunction

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  task automatic write(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic reserve(input int a);
    rsv_en = 1'b1; rsv_addr = AW'(a);
    cyc();
    rsv_en = 1'b0;
  endtask

  // Count cycles with ready low until ready rises (bounded).
  task automatic wait_ready(inout int n);
    while (!ready && n < 200) begin
      cyc();
      n++;
      settle();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    set_rd(5, 0, 7, 31);
    cyc(); cyc();
    settle();
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rd_data_p0", port_data(0), 32'h0);
    check("reset_rd_busy", 32'(rd_busy), 32'h0);

    // Initial sweep length.
    rst = 1'b0;
    n = 0;
    settle();
    wait_ready(n);
    check("sweep_cycles", 32'(n), 32'd31);
    check("ready_after_sweep", 32'(ready), 32'd1);

    // Basic write/read.
    write(5, 32'hDEADBEEF);
    set_rd(5, 5, 0, 0); settle();
    check("x5_read", port_data(0), 32'hDEADBEEF);
    check("x5_read_p1", port_data(1), 32'hDEADBEEF);

    // x0 handling: write and reserve x0 together.
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = '0;
    cyc();
    idle();
    set_rd(0, 0, 0, 0); settle();
    for (int p = 0; p < NR; p++) check($sformatf("x0_data_p%0d", p), port_data(p), 32'h0);
    check("x0_busy", 32'(rd_busy), 32'h0);

    // Scoreboard on x7.
    set_rd(7, 0, 0, 0);
    rsv_en = 1'b1; rsv_addr = AW'(7); settle();
    check("x7_busy_rsv_cycle", 32'(rd_busy[0]), 32'd0);
    cyc(); rsv_en = 1'b0; settle();
    check("x7_busy_after_rsv", 32'(rd_busy[0]), 32'd1);
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h12345678; settle();
`ifdef REGFILE_BYPASS_EN
    check("x7_data_wr_cycle", port_data(0), 32'h12345678);
    check("x7_busy_wr_cycle", 32'(rd_busy[0]), 32'd0);
`else
    check("x7_data_wr_cycle", port_data(0), 32'h0);
    check("x7_busy_wr_cycle", 32'(rd_busy[0]), 32'd1);
`endif
    cyc(); wr_en = 1'b0; settle();
    check("x7_data_after_wr", port_data(0), 32'h12345678);
    check("x7_busy_after_wr", 32'(rd_busy[0]), 32'd0);
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h00000011;
    rsv_en = 1'b1; rsv_addr = AW'(7);
    cyc(); idle(); settle();
    check("x7_data_wr_rsv", port_data(0), 32'h00000011);
    check("x7_busy_wr_rsv", 32'(rd_busy[0]), 32'd1);
    write(7, 32'h22); settle();
    check("x7_busy_cleared", 32'(rd_busy[0]), 32'd0);

    // Bypass behaviour on x3 with a prior reservation.
    write(3, 32'h33);
    reserve(3);
    set_rd(3, 3, 0, 0);
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'hA5A5A5A5; settle();
`ifdef REGFILE_BYPASS_EN
    check("byp_data_p0", port_data(0), 32'hA5A5A5A5);
    check("byp_busy_p0", 32'(rd_busy[0]), 32'd0);
`else
    check("byp_data_p0", port_data(0), 32'h33);
    check("byp_busy_p0", 32'(rd_busy[0]), 32'd1);
`endif
    cyc(); wr_en = 1'b0; settle();
    check("x3_after_wr_p1", port_data(1), 32'hA5A5A5A5);
    check("x3_busy_after_wr", 32'(rd_busy), 32'h0);

    // Multi-port: distinct and identical registers.
    write(1, 32'd1); write(2, 32'd2); write(31, 32'd31);
    set_rd(1, 2, 1, 31); settle();
    check("mp_p0", port_data(0), 32'd1);
    check("mp_p1", port_data(1), 32'd2);
    check("mp_p2", port_data(2), 32'd1);
    check("mp_p3", port_data(3), 32'd31);
    set_rd(2, 2, 2, 2); settle();
    for (int p = 0; p < NR; p++) check($sformatf("mp_same_p%0d", p), port_data(p), 32'd2);

    // Mid-operation reset with a write to x9 and a busy x12.
    write(9, 32'h99);
    reserve(12);
    set_rd(9, 12, 5, 31); settle();
    check("x9_before_rst", port_data(0), 32'h99);
    check("x12_busy_before_rst", 32'(rd_busy[1]), 32'd1);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h77;
    cyc();
    rst = 1'b0;
    n = 0;
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h55;
    rsv_en = 1'b1; rsv_addr = AW'(9);
    settle();
    check("init_ready", 32'(ready), 32'd0);
    check("init_rd_data_p0", port_data(0), 32'h0);
    check("init_rd_busy", 32'(rd_busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(); n++;
    end
    idle();
    settle();
    wait_ready(n);
    check("resweep_cycles", 32'(n), 32'd31);
    check("x9_after_resweep", port_data(0), 32'h0);
    check("x5_after_resweep", port_data(2), 32'h0);
    check("x31_after_resweep", port_data(3), 32'h0);
    check("busy_after_resweep", 32'(rd_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
